// File: rtl/dsp_addsub_arbiter_pkg.sv
// Shared definitions for the DSP add/sub arbiter: FSM encoding, op codes, datapath width.
package dsp_addsub_arbiter_pkg;

    localparam int DATA_W = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dsp_addsub_arbiter_core.sv
// Combinational 32-bit add/sub matching the MAC16 bypassed adder: two 16-bit halves,
// the upper half taking the lower half's carry out, subtract as a + ~b + 1.
module dsp_addsub_arbiter_core
    import dsp_addsub_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W-1:0] b_eff;
    logic [16:0]       sum_lo;
    logic [16:0]       sum_hi;

    always_comb begin
        b_eff  = sub ? ~b : b;
        // The +1 for subtract enters at the bottom half; add uses CI=0.
        sum_lo = {1'b0, a[15:0]} + {1'b0, b_eff[15:0]} + {16'd0, sub};
        sum_hi = {1'b0, a[31:16]} + {1'b0, b_eff[31:16]} + {16'd0, sum_lo[16]};
        result = {sum_hi[15:0], sum_lo[15:0]};
        carry  = sum_hi[16];
    end

endmodule

// File: rtl/dsp_addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub DSP path among NREQ requesters,
// one operation in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold until taken).
module dsp_addsub_arbiter
    import dsp_addsub_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_op,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_result,
    output logic                   rsp_carry
);

    localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IDW-1:0]    last_grant;
    logic [IDW-1:0]    grant_idx;
    logic              grant_any;
    logic [IDW:0]      cand;
    logic              accept;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_sub;
    logic [IDW-1:0]    op_id;
    logic [DATA_W-1:0] core_result;
    logic              core_carry;

    logic [DATA_W-1:0] a_arr [NREQ];
    logic [DATA_W-1:0] b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DATA_W +: DATA_W];
        assign b_arr[i] = req_b[i*DATA_W +: DATA_W];
    end

    // Scan downward so the candidate closest after last_grant is the one left standing.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = {1'b0, last_grant} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (req_valid[cand[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
    end

    assign accept = (state == S_IDLE) && grant_any;

    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (grant_any) state_nxt = S_EXEC;
            S_EXEC: state_nxt = S_RESP;
            S_RESP: if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= LAST_RST;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= OP_ADD;
            op_id      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
        end else begin
            if (accept) begin
                op_a       <= a_arr[grant_idx];
                op_b       <= b_arr[grant_idx];
                op_sub     <= req_op[grant_idx];
                op_id      <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == S_EXEC) begin
                rsp_result <= core_result;
                rsp_carry  <= core_carry;
                rsp_id     <= op_id;
                rsp_valid  <= 1'b1;
            end else if (state == S_RESP && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

    dsp_addsub_arbiter_core u_core (
        .a      (op_a),
        .b      (op_b),
        .sub    (op_sub),
        .result (core_result),
        .carry  (core_carry)
    );

endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// Scoreboard bench for dsp_addsub_arbiter: directed ops push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_dsp_addsub_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    res;
        logic           c;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_op;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_result;
    logic              rsp_carry;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    dsp_addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [IDW-1:0] id, input logic [31:0] res, input logic c);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.c   = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d result=%h carry=%0d, none expected",
                         rsp_id, rsp_result, rsp_carry);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rsp_id !== e.id || rsp_result !== e.res || rsp_carry !== e.c) begin
                    errors++;
                    $display("FAIL rsp: got id=%0d result=%h carry=%0d, expected id=%0d result=%h carry=%0d",
                             rsp_id, rsp_result, rsp_carry, e.id, e.res, e.c);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Presents one op, waits (bounded) for its grant; returns grant cycle or -1.
    task automatic issue(input int idx, input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ec, input logic push, output int gc);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        req_op[idx] = op;
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_valid[idx] = 1'b1;
        if (push) exp_q.push_back(mk(IDW'(idx), er, ec));
        gc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                gc = cyc;
                break;
            end
        end
        checks++;
        if (gc < 0) begin
            errors++;
            $display("FAIL grant_timeout: req%0d never granted, req_ready=%b", idx, req_ready);
        end else begin
            check("grant_onehot", 64'(req_ready), 64'(oh));
        end
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    int gc;
    int grants;
    int last_gc;
    int seen;

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);
        check("rst_rsp_carry", 64'(rsp_carry), 64'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single add and latency
        issue(0, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b1, gc);
        seen = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = cyc;
                break;
            end
        end
        check("latency", 64'(seen - gc), 64'd2);
        drain();

        // 2: subtract with and without borrow; 3: add overflow
        issue(1, 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b1, gc);
        drain();
        issue(0, 1'b1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b1, gc);
        drain();
        issue(1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, gc);
        drain();

        // 4: contention, last grant was 1 so order is 0,1,0,1 every 3 cycles
        req_op = 2'b10;
        req_a  = {32'h1000_0000, 32'h1234_5678};
        req_b  = {32'h0000_0001, 32'h1111_1111};
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_q.push_back(mk(1'b0, 32'h2345_6789, 1'b0));
            else            exp_q.push_back(mk(1'b1, 32'h0FFF_FFFF, 1'b1));
        end
        req_valid = 2'b11;
        grants = 0;
        last_gc = 0;
        for (int i = 0; i < 40 && grants < 4; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("contention_grant", 64'(req_ready), (grants % 2 == 0) ? 64'd1 : 64'd2);
                if (grants > 0) check("contention_spacing", 64'(cyc - last_gc), 64'd3);
                last_gc = cyc;
                grants++;
            end
        end
        check("contention_count", 64'(grants), 64'd4);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // 5: backpressure with a competing request waiting
        rsp_ready = 1'b0;
        issue(0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, gc);
        req_op[1] = 1'b1;
        req_a[63:32] = 32'h0001_0000;
        req_b[63:32] = 32'h0001_0000;
        req_valid[1] = 1'b1;
        exp_q.push_back(mk(1'b1, 32'h0000_0000, 1'b1));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        check("bp_rsp_seen", 64'(seen), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {29'd0, rsp_valid, rsp_carry, req_ready, rsp_result},
                  {29'd0, 1'b1, 1'b1, 2'b00, 32'h0000_0000});
            check("bp_id", 64'(rsp_id), 64'd0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        check("bp_next_accept", 64'(req_ready), 64'd2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        drain();

        // 6: reset while the op is in EXEC; its response must never appear
        issue(0, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0, 1'b0, 1'b0, gc);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_quiet", {31'd0, rsp_valid, rsp_result}, 64'd0);
        end
        @(posedge clk);
        #1;
        req_op[1] = 1'b1;
        req_a[63:32] = 32'h0000_0000;
        req_b[63:32] = 32'h0000_0001;
        req_valid[1] = 1'b1;
        issue(0, 1'b0, 32'h0000_000A, 32'h0000_0005, 32'h0000_000F, 1'b0, 1'b1, gc);
        issue(1, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, gc);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, %0d checks so far", checks);
        $fatal(1, "timeout");
    end

endmodule
